// File: rtl/orient_sched_ctrl_if.sv
// Orientation scheduler bus: start request in, per-unit issue/writeback strobes and run status out.
// No backpressure; the controller drives every output and samples start only while idle.
interface orient_sched_ctrl_if;
  logic        start;
  logic        busy;
  logic [3:0]  step;
  logic [6:0]  fu_en;
  logic [13:0] fu_axis;
  logic        add_mode;
  logic [6:0]  fu_wb;
  logic        done;
  logic [7:0]  run_cycles;

  modport master (
    input  start,
    output busy, step, fu_en, fu_axis, add_mode, fu_wb, done, run_cycles
  );

  modport slave (
    output start,
    input  busy, step, fu_en, fu_axis, add_mode, fu_wb, done, run_cycles
  );
endinterface

// File: rtl/orient_sched_ctrl.sv
// 12-step orientation schedule sequencer; each step dwells for its slowest unit, start is ignored unless idle.
// ORIENT_SCHED_ABORT_EN adds an abort input that cancels a run without done or run_cycles update.
module orient_sched_ctrl #(
  parameter int ADD_LAT  = 1,
  parameter int DIV_LAT  = 3,
  parameter int SQ_LAT   = 2,
  parameter int SQRT_LAT = 4,
  parameter int MUL_LAT  = 2,
  parameter int ATAN_LAT = 4
) (
  input  logic clk,
  input  logic rst,
`ifdef ORIENT_SCHED_ABORT_EN
  input  logic abort,
`endif
  orient_sched_ctrl_if.master bus
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_ISSUE = 2'd1;
  localparam logic [1:0] S_WAIT  = 2'd2;
  localparam logic [1:0] S_DONE  = 2'd3;

  localparam logic [1:0] AX_X = 2'd0;
  localparam logic [1:0] AX_Y = 2'd1;
  localparam logic [1:0] AX_Z = 2'd2;

  // Index matches fu_en bit order: add0, add1, div, sq, sqrt, mul, atan.
  localparam logic [6:0][3:0] LAT = {4'(ATAN_LAT), 4'(MUL_LAT), 4'(SQRT_LAT), 4'(SQ_LAT),
                                     4'(DIV_LAT), 4'(ADD_LAT), 4'(ADD_LAT)};

  logic [1:0]  state;
  logic [3:0]  step_q;
  logic [3:0]  dwell;
  logic [7:0]  cyc_cnt;
  logic [7:0]  run_q;

  logic [6:0]  rom_en;
  logic [13:0] rom_axis;
  logic [3:0]  lmax;
  logic [3:0]  elapsed;
  logic [6:0]  wb;
  logic        active;
  logic        step_done;
  logic        abort_hit;
  logic [7:0]  cyc_inc;

  always_comb begin
    rom_en   = '0;
    rom_axis = '0;
    case (step_q)
      4'd0:  begin rom_en = 7'b0000011; rom_axis[1:0] = AX_X; rom_axis[3:2] = AX_Y; end
      4'd1:  begin rom_en = 7'b0000101; rom_axis[1:0] = AX_Z; rom_axis[5:4] = AX_X; end
      4'd2:  begin rom_en = 7'b0000100; rom_axis[5:4] = AX_Y; end
      4'd3:  begin rom_en = 7'b0001100; rom_axis[5:4] = AX_Z; rom_axis[7:6] = AX_X; end
      4'd4:  begin rom_en = 7'b0001000; rom_axis[7:6] = AX_Y; end
      4'd5:  begin rom_en = 7'b0001000; rom_axis[7:6] = AX_Z; end
      4'd6:  begin rom_en = 7'b0000011; rom_axis[1:0] = AX_X; rom_axis[3:2] = AX_Y; end
      4'd7:  begin rom_en = 7'b0010001; rom_axis[1:0] = AX_Z; rom_axis[9:8] = AX_X; end
      4'd8:  begin rom_en = 7'b0110000; rom_axis[9:8] = AX_Y; rom_axis[11:10] = AX_X; end
      4'd9:  begin
        rom_en = 7'b1110000;
        rom_axis[9:8] = AX_Z; rom_axis[11:10] = AX_Y; rom_axis[13:12] = AX_X;
      end
      4'd10: begin rom_en = 7'b1100000; rom_axis[11:10] = AX_Z; rom_axis[13:12] = AX_Y; end
      4'd11: begin rom_en = 7'b1000000; rom_axis[13:12] = AX_Z; end
      default: begin rom_en = '0; rom_axis = '0; end
    endcase
  end

  always_comb begin
    lmax = 4'd1;
    for (int u = 0; u < 7; u++) begin
      if (rom_en[u] && (LAT[u] > lmax)) lmax = LAT[u];
    end
  end

  assign active  = (state == S_ISSUE) || (state == S_WAIT);
  // Cycles since this step issued; the dwell counter counts down from lmax-1.
  assign elapsed = (state == S_WAIT) ? (lmax - dwell) : 4'd0;

  always_comb begin
    wb = '0;
    for (int u = 0; u < 7; u++) begin
      wb[u] = active && rom_en[u] && (elapsed == (LAT[u] - 4'd1));
    end
  end

  assign step_done = ((state == S_ISSUE) && (lmax == 4'd1)) ||
                     ((state == S_WAIT) && (dwell == 4'd1));
  assign cyc_inc   = (cyc_cnt == 8'hFF) ? 8'hFF : (cyc_cnt + 8'd1);

`ifdef ORIENT_SCHED_ABORT_EN
  assign abort_hit = abort && active;
`else
  assign abort_hit = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= S_IDLE;
      step_q  <= 4'd0;
      dwell   <= 4'd0;
      cyc_cnt <= 8'd0;
      run_q   <= 8'd0;
    end else begin
      case (state)
        S_IDLE: begin
          if (bus.start) begin
            state   <= S_ISSUE;
            step_q  <= 4'd0;
            cyc_cnt <= 8'd0;
          end
        end
        S_ISSUE, S_WAIT: begin
          cyc_cnt <= cyc_inc;
          dwell   <= (state == S_ISSUE) ? (lmax - 4'd1) : (dwell - 4'd1);
          if (abort_hit) begin
            state  <= S_IDLE;
            step_q <= 4'd0;
          end else if (step_done) begin
            if (step_q == 4'd11) begin
              state  <= S_DONE;
              step_q <= 4'd0;
              run_q  <= cyc_inc;
            end else begin
              state  <= S_ISSUE;
              step_q <= step_q + 4'd1;
            end
          end else begin
            state <= S_WAIT;
          end
        end
        S_DONE:  state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end

  assign bus.busy       = active;
  assign bus.step       = step_q;
  assign bus.fu_en      = (state == S_ISSUE) ? rom_en : 7'd0;
  assign bus.fu_axis    = active ? rom_axis : 14'd0;
  assign bus.add_mode   = active && ((step_q == 4'd6) || (step_q == 4'd7));
  assign bus.fu_wb      = wb;
  assign bus.done       = (state == S_DONE);
  assign bus.run_cycles = run_q;

endmodule

// File: tb/tb_orient_sched_ctrl.sv
// Bench for orient_sched_ctrl: default-latency and all-ones-latency instances checked against a per-cycle scoreboard.
module tb_orient_sched_ctrl;

  typedef struct packed {
    logic        busy;
    logic [3:0]  step;
    logic [6:0]  en;
    logic [13:0] axis;
    logic        add_mode;
    logic [6:0]  wb;
    logic        done;
  } obs_t;

  localparam logic [6:0] EN_TAB [12] = '{
    7'b0000011, 7'b0000101, 7'b0000100, 7'b0001100, 7'b0001000, 7'b0001000,
    7'b0000011, 7'b0010001, 7'b0110000, 7'b1110000, 7'b1100000, 7'b1000000};
  localparam logic [13:0] AX_TAB [12] = '{
    14'h0004, 14'h0002, 14'h0010, 14'h0020, 14'h0040, 14'h0080,
    14'h0004, 14'h0002, 14'h0100, 14'h0600, 14'h1800, 14'h2000};
  localparam int LAT_D [7] = '{1, 1, 3, 2, 4, 2, 4};

  logic clk = 1'b0;
  logic rst;
  int   n_checks = 0;
  int   n_fail = 0;
  obs_t exp_q[$];

  always #5 clk = ~clk;

  orient_sched_ctrl_if bus_d ();
  orient_sched_ctrl_if bus_f ();

`ifdef ORIENT_SCHED_ABORT_EN
  logic abort_d;
`endif

  orient_sched_ctrl dut_d (
    .clk   (clk),
    .rst   (rst),
`ifdef ORIENT_SCHED_ABORT_EN
    .abort (abort_d),
`endif
    .bus   (bus_d.master)
  );

  orient_sched_ctrl #(
    .ADD_LAT(1), .DIV_LAT(1), .SQ_LAT(1), .SQRT_LAT(1), .MUL_LAT(1), .ATAN_LAT(1)
  ) dut_f (
    .clk   (clk),
    .rst   (rst),
`ifdef ORIENT_SCHED_ABORT_EN
    .abort (1'b0),
`endif
    .bus   (bus_f.master)
  );

  function automatic obs_t obs_d();
    return {bus_d.busy, bus_d.step, bus_d.fu_en, bus_d.fu_axis, bus_d.add_mode, bus_d.fu_wb, bus_d.done};
  endfunction

  function automatic obs_t obs_f();
    return {bus_f.busy, bus_f.step, bus_f.fu_en, bus_f.fu_axis, bus_f.add_mode, bus_f.fu_wb, bus_f.done};
  endfunction

  function automatic int lat_of(int u, bit fast);
    return fast ? 1 : LAT_D[u];
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One entry per cycle from the first issue through the done pulse.
  task automatic push_run(input bit fast);
    int   dw;
    obs_t e;
    for (int s = 0; s < 12; s++) begin
      dw = 0;
      for (int u = 0; u < 7; u++)
        if (EN_TAB[s][u] && lat_of(u, fast) > dw) dw = lat_of(u, fast);
      for (int d = 0; d < dw; d++) begin
        e          = '0;
        e.busy     = 1'b1;
        e.step     = 4'(s);
        e.en       = (d == 0) ? EN_TAB[s] : 7'd0;
        e.axis     = AX_TAB[s];
        e.add_mode = (s == 6) || (s == 7);
        for (int u = 0; u < 7; u++)
          if (EN_TAB[s][u] && (lat_of(u, fast) - 1 == d)) e.wb[u] = 1'b1;
        exp_q.push_back(e);
      end
    end
    e      = '0;
    e.done = 1'b1;
    exp_q.push_back(e);
  endtask

  task automatic test_reset();
    rst = 1'b1;
    tick();
    tick();
    n_checks++;
    if ({obs_d(), bus_d.run_cycles, obs_f(), bus_f.run_cycles} !== '0) begin
      n_fail++;
      $display("FAIL reset_state: got %h/%h want all zero", obs_d(), obs_f());
    end
    rst = 1'b0;
    for (int i = 0; i < 10; i++) begin
      tick();
      n_checks++;
      if (obs_d() !== '0 || bus_d.run_cycles !== 8'd0 || obs_f() !== '0 || bus_f.run_cycles !== 8'd0) begin
        n_fail++;
        $display("FAIL reset_idle cycle %0d: got %h/%h want all zero", i, obs_d(), obs_f());
      end
    end
  endtask

  task automatic test_default_run();
    obs_t o, e;
    exp_q.delete();
    push_run(1'b0);
    bus_d.start = 1'b1;
    for (int off = 1; off <= 36; off++) begin
      tick();
      bus_d.start = 1'b0;
      o = obs_d();
      e = exp_q.pop_front();
      n_checks++;
      if (o !== e) begin
        n_fail++;
        $display("FAIL sb_default off %0d: got %h want %h", off, o, e);
      end
      case (off)
        1: begin
          n_checks++;
          if (bus_d.fu_en !== 7'b0000011) begin
            n_fail++; $display("FAIL step0_en: got %b want 0000011", bus_d.fu_en);
          end
        end
        8: begin
          n_checks++;
          if ({bus_d.fu_en, bus_d.fu_axis[7:4]} !== {7'b0001100, 4'b0010}) begin
            n_fail++; $display("FAIL step3_en_axis: got %b/%b want 0001100/0010", bus_d.fu_en, bus_d.fu_axis[7:4]);
          end
        end
        24: begin
          n_checks++;
          if (bus_d.fu_en !== 7'b1110000) begin
            n_fail++; $display("FAIL step9_issue: got %b want 1110000", bus_d.fu_en);
          end
        end
        25: begin
          n_checks++;
          if (bus_d.fu_wb !== 7'b0100000) begin
            n_fail++; $display("FAIL step9_wb_mul: got %b want 0100000", bus_d.fu_wb);
          end
        end
        27: begin
          n_checks++;
          if (bus_d.fu_wb !== 7'b1010000) begin
            n_fail++; $display("FAIL step9_wb_sqrt_atan: got %b want 1010000", bus_d.fu_wb);
          end
        end
        28: begin
          n_checks++;
          if ({bus_d.fu_en, bus_d.step} !== {7'b1100000, 4'd10}) begin
            n_fail++; $display("FAIL step10_issue: got %b/%0d want 1100000/10", bus_d.fu_en, bus_d.step);
          end
        end
        36: begin
          n_checks++;
          if ({bus_d.done, bus_d.busy, bus_d.run_cycles} !== {1'b1, 1'b0, 8'd35}) begin
            n_fail++;
            $display("FAIL done_default: got done=%b busy=%b run=%0d want 1/0/35", bus_d.done, bus_d.busy, bus_d.run_cycles);
          end
        end
        default: ;
      endcase
    end
    tick();
  endtask

  task automatic test_all_lat1();
    obs_t o, e;
    exp_q.delete();
    push_run(1'b1);
    bus_f.start = 1'b1;
    for (int off = 1; off <= 13; off++) begin
      tick();
      bus_f.start = 1'b0;
      o = obs_f();
      e = exp_q.pop_front();
      n_checks++;
      if (o !== e) begin
        n_fail++;
        $display("FAIL sb_lat1 off %0d: got %h want %h", off, o, e);
      end
      if (off <= 12) begin
        n_checks++;
        if (bus_f.fu_wb !== bus_f.fu_en || bus_f.fu_en === 7'd0) begin
          n_fail++; $display("FAIL lat1_wb_eq_en off %0d: got en=%b wb=%b", off, bus_f.fu_en, bus_f.fu_wb);
        end
      end
    end
    n_checks++;
    if (bus_f.run_cycles !== 8'd12) begin
      n_fail++; $display("FAIL lat1_run_cycles: got %0d want 12", bus_f.run_cycles);
    end
    tick();
  endtask

  task automatic test_start_ignored();
    obs_t o, e;
    bit   got;
    exp_q.delete();
    push_run(1'b0);
    bus_d.start = 1'b1;
    for (int off = 1; off <= 36; off++) begin
      tick();
      o = obs_d();
      e = exp_q.pop_front();
      n_checks++;
      if (o !== e) begin
        n_fail++;
        $display("FAIL sb_start_ignored off %0d: got %h want %h", off, o, e);
      end
      bus_d.start = (off == 13);
      if (off == 36) bus_d.start = 1'b1;
    end
    tick();
    n_checks++;
    if (obs_d() !== '0) begin
      n_fail++; $display("FAIL start_in_done: got %h want idle zero", obs_d());
    end
    tick();
    bus_d.start = 1'b0;
    n_checks++;
    if ({bus_d.busy, bus_d.step, bus_d.fu_en} !== {1'b1, 4'd0, 7'b0000011}) begin
      n_fail++; $display("FAIL restart_accept: got busy=%b step=%0d en=%b", bus_d.busy, bus_d.step, bus_d.fu_en);
    end
    got = 1'b0;
    for (int i = 0; i < 60 && !got; i++) begin
      tick();
      if (bus_d.done) got = 1'b1;
    end
    n_checks++;
    if (!got) begin
      n_fail++; $display("FAIL restart_done: got no done want done within 60 cycles");
    end
    tick();
  endtask

`ifdef ORIENT_SCHED_ABORT_EN
  task automatic test_abort();
    bit seen;
    int i;
    bus_d.start = 1'b1;
    tick();
    bus_d.start = 1'b0;
    for (i = 0; i < 40 && !(bus_d.busy && bus_d.step == 4'd8); i++) tick();
    n_checks++;
    if (!(bus_d.busy && bus_d.step == 4'd8)) begin
      n_fail++; $display("FAIL abort_reach_step8: got step=%0d want 8", bus_d.step);
    end
    abort_d = 1'b1;
    tick();
    abort_d = 1'b0;
    n_checks++;
    if (obs_d() !== '0 || bus_d.run_cycles !== 8'd35) begin
      n_fail++; $display("FAIL abort_idle: got %h run=%0d want zero/35", obs_d(), bus_d.run_cycles);
    end
    seen = 1'b0;
    for (int k = 0; k < 40; k++) begin
      tick();
      if (bus_d.done || bus_d.fu_wb !== 7'd0) seen = 1'b1;
    end
    n_checks++;
    if (seen) begin
      n_fail++; $display("FAIL abort_no_done: got done/wb after abort want none");
    end
  endtask
`endif

  task automatic test_rst_mid();
    bit seen;
    int i;
    n_checks++;
    if (bus_d.run_cycles !== 8'd35) begin
      n_fail++; $display("FAIL rst_pre_run_cycles: got %0d want 35", bus_d.run_cycles);
    end
    bus_d.start = 1'b1;
    tick();
    bus_d.start = 1'b0;
    for (i = 0; i < 40 && !(bus_d.busy && bus_d.step == 4'd8); i++) tick();
    n_checks++;
    if (!(bus_d.busy && bus_d.step == 4'd8)) begin
      n_fail++; $display("FAIL rst_reach_step8: got step=%0d want 8", bus_d.step);
    end
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    n_checks++;
    if (obs_d() !== '0 || bus_d.run_cycles !== 8'd0) begin
      n_fail++; $display("FAIL rst_mid_outputs: got %h run=%0d want zero/0", obs_d(), bus_d.run_cycles);
    end
    seen = 1'b0;
    for (int k = 0; k < 40; k++) begin
      tick();
      if (bus_d.done || bus_d.fu_wb !== 7'd0 || bus_d.busy) seen = 1'b1;
    end
    n_checks++;
    if (seen) begin
      n_fail++; $display("FAIL rst_mid_no_done: got activity after reset want none");
    end
  endtask

  initial begin
    rst = 1'b1;
    bus_d.start = 1'b0;
    bus_f.start = 1'b0;
`ifdef ORIENT_SCHED_ABORT_EN
    abort_d = 1'b0;
`endif
    test_reset();
    test_default_run();
    test_all_lat1();
    test_start_ignored();
`ifdef ORIENT_SCHED_ABORT_EN
    test_abort();
`endif
    test_rst_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
